// File: rtl/regfile_wb_arbiter.sv
// Write-side front end for the register file: merges the non-stallable ALU result
// stream with FIFO-buffered load results onto the single register-file write port.
module regfile_wb_arbiter #(
   parameter int N     = 64,
   parameter int R     = 32,
   parameter int ASIZE = $clog2(R),
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alu_valid,
   input  logic [ASIZE-1:0] alu_rd,
   input  logic [N-1:0]     alu_data,
   input  logic             ld_valid,
   input  logic [ASIZE-1:0] ld_rd,
   input  logic [N-1:0]     ld_data,
   output logic             ld_ready,
   input  logic [ASIZE-1:0] chk_id,
   output logic             chk_busy,
   output logic             wr,
   output logic [ASIZE-1:0] reg_id_w,
   output logic [N-1:0]     data_in,
   output logic [CW:0]      q_count
);

   localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);

   logic [DEPTH-1:0] live_q, live_d;
   logic [ASIZE-1:0] rd_q  [DEPTH];
   logic [N-1:0]     dat_q [DEPTH];
   logic [CW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW:0]      count_q, count_d;
   logic             wr_q, wr_d;
   logic [ASIZE-1:0] id_q, id_d;
   logic [N-1:0]     wdata_q, wdata_d;
   logic             enq, deq;

   assign ld_ready = (count_q != FULL_CNT);
   assign enq      = ld_valid & ld_ready;
   assign deq      = ~alu_valid & (count_q != '0);

   always_comb begin
      live_d  = live_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      wr_d    = 1'b0;
      id_d    = id_q;
      wdata_d = wdata_q;
      // ALU result is younger than every queued load, so older loads to the same rd die
      if (alu_valid) begin
         wr_d    = 1'b1;
         id_d    = alu_rd;
         wdata_d = alu_data;
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
         end
      end else if (deq) begin
         wr_d           = live_q[head_q];
         id_d           = rd_q[head_q];
         wdata_d        = dat_q[head_q];
         live_d[head_q] = 1'b0;
         head_d         = head_q + CW'(1);
      end
      if (enq) begin
         live_d[tail_q] = 1'b1;
         tail_d         = tail_q + CW'(1);
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + (CW+1)'(1);
         2'b01:   count_d = count_q - (CW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         wr_q    <= 1'b0;
         id_q    <= '0;
         wdata_q <= '0;
      end else begin
         live_q  <= live_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         id_q    <= id_d;
         wdata_q <= wdata_d;
      end
   end

   // Payload storage is qualified by live bits, so it needs no reset
   always_ff @(posedge clk) begin
      if (enq) begin
         rd_q[tail_q]  <= ld_rd;
         dat_q[tail_q] <= ld_data;
      end
   end

   always_comb begin
      chk_busy = wr_q & (id_q == chk_id);
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i] && (rd_q[i] == chk_id)) chk_busy = 1'b1;
      end
   end

   assign wr       = wr_q;
   assign reg_id_w = id_q;
   assign data_in  = wdata_q;
   assign q_count  = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, all checked
// against a queue-based model of the write-back rules.
module tb_regfile_wb_arbiter;
   localparam int N     = 64;
   localparam int ASIZE = 5;
   localparam int DEPTH = 4;
   localparam int QW    = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             alu_valid = 1'b0;
   logic [ASIZE-1:0] alu_rd = '0;
   logic [N-1:0]     alu_data = '0;
   logic             ld_valid = 1'b0;
   logic [ASIZE-1:0] ld_rd = '0;
   logic [N-1:0]     ld_data = '0;
   logic             ld_ready;
   logic [ASIZE-1:0] chk_id = '0;
   logic             chk_busy;
   logic             wr;
   logic [ASIZE-1:0] reg_id_w;
   logic [N-1:0]     data_in;
   logic [QW-1:0]    q_count;

   regfile_wb_arbiter #(.N(N), .R(32), .ASIZE(ASIZE), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .chk_id(chk_id), .chk_busy(chk_busy),
      .wr(wr), .reg_id_w(reg_id_w), .data_in(data_in), .q_count(q_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               live;
      logic [ASIZE-1:0] rd;
      logic [N-1:0]     data;
   } ent_t;

   ent_t             mq[$];
   logic             m_wr   = 1'b0;
   logic [ASIZE-1:0] m_id   = '0;
   logic [N-1:0]     m_data = '0;
   int               tests  = 0;
   int               fails  = 0;
   int               n_r3_33 = 0;

   task automatic chk(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return mq.size() != DEPTH;
   endfunction

   function automatic bit m_busy(logic [ASIZE-1:0] id);
      if (m_wr && m_id == id) return 1'b1;
      foreach (mq[i]) if (mq[i].live && mq[i].rd == id) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all(string tag);
      chk({tag, ".wr"},       N'(wr),       N'(m_wr));
      chk({tag, ".reg_id_w"}, N'(reg_id_w), N'(m_id));
      chk({tag, ".data_in"},  data_in,      m_data);
      chk({tag, ".q_count"},  N'(q_count),  N'(mq.size()));
      chk({tag, ".ld_ready"}, N'(ld_ready), N'(m_ready()));
      chk({tag, ".chk_busy"}, N'(chk_busy), N'(m_busy(chk_id)));
   endtask

   // One clock edge of the write-back rules, applied to the inputs as sampled
   task automatic model_edge();
      ent_t e;
      bit   enq;
      enq = ld_valid && m_ready();
      if (alu_valid) begin
         foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
         m_wr = 1'b1; m_id = alu_rd; m_data = alu_data;
      end else if (mq.size() > 0) begin
         e = mq.pop_front();
         m_wr = e.live; m_id = e.rd; m_data = e.data;
      end else begin
         m_wr = 1'b0;
      end
      if (enq) begin
         e.live = 1'b1; e.rd = ld_rd; e.data = ld_data;
         mq.push_back(e);
      end
   endtask

   // Entered ~1ns after a posedge with inputs already applied
   task automatic step(string tag, output bit accepted);
      #1 check_all(tag);
      accepted = ld_valid && m_ready();
      @(posedge clk);
      model_edge();
      #1;
      if (wr && reg_id_w == 5'd3 && data_in == 64'h33) n_r3_33++;
   endtask

   task automatic drive(bit av, logic [ASIZE-1:0] ard, logic [N-1:0] ad,
                        bit lv, logic [ASIZE-1:0] lrd, logic [N-1:0] ld);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      ld_valid = lv; ld_rd = lrd; ld_data = ld;
   endtask

   initial begin
      bit acc;
      int idx;
      // Reset state
      #1 check_all("reset");
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // 1: ALU only
      drive(1, 5'd5, 64'hA5, 0, 0, 0); step("t1_alu", acc);
      drive(0, 0, 0, 0, 0, 0);         step("t1_idle", acc);
      step("t1_wr0", acc);
      chk("t1_wr_low", N'(wr), 0);

      // 2: ALU priority over queued loads
      drive(1, 5'd7, 64'h77, 1, 5'd1, 64'h11); step("t2_a", acc);
      drive(1, 5'd7, 64'h78, 1, 5'd2, 64'h22); step("t2_b", acc);
      drive(1, 5'd7, 64'h79, 0, 0, 0);         step("t2_c", acc);
      chk("t2_qcount2", N'(q_count), 2);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("t2_drain", acc);

      // 3: full FIFO backpressure
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         drive(c < 6, 5'd8, 64'h800 + 64'(c), idx < 5, 5'(10 + idx), 64'h100 + 64'(idx));
         step("t3", acc);
         if (acc) idx++;
         if (c == 5) begin
            chk("t3_full_qcount", N'(q_count), 4);
            chk("t3_full_ready", N'(ld_ready), 0);
         end
      end
      chk("t3_all_accepted", N'(idx), 5);

      // 4: squash of a queued load by a younger ALU write
      chk_id = 5'd3;
      drive(1, 5'd4, 64'h44, 1, 5'd3, 64'h33); step("t4_a", acc);
      drive(1, 5'd3, 64'h99, 0, 0, 0);         step("t4_b", acc);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("t4_drain", acc);
      chk("t4_no_stale_r3", N'(n_r3_33), 0);

      // 5: busy check
      chk_id = 5'd9;
      drive(1, 5'd1, 64'h1, 1, 5'd9, 64'h9999); step("t5_a", acc);
      drive(0, 0, 0, 0, 0, 0);
      step("t5_b", acc);
      step("t5_c", acc);
      chk_id = 5'd10;
      step("t5_d", acc);

      // 6: asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'd2, 64'h200 + 64'(i), 1, 5'(11 + i), 64'h300 + 64'(i));
         step("t6_fill", acc);
      end
      drive(0, 0, 0, 0, 0, 0);
      #2 rst = 1'b0;
      #1;
      mq.delete(); m_wr = 1'b0; m_id = '0; m_data = '0;
      check_all("t6_async");
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) step("t6_after", acc);

      // Random traffic with narrow register ids to exercise squash and busy
      for (int c = 0; c < 400; c++) begin
         drive(($urandom % 3) == 0, 5'($urandom_range(7, 0)), {$urandom, $urandom},
               ($urandom % 4) != 0, 5'($urandom_range(7, 0)), {$urandom, $urandom});
         chk_id = 5'($urandom_range(7, 0));
         step("rand", acc);
      end
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step("final_drain", acc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
